adc_pulse_emulator: RTL and testbench

Synthetic ADC sample source. It drives the same 16-bit sample / sample-strobe / overflow interface that the threshold comparator and moving-average path consume. It generates negative-going pulses on a programmable baseline, with a linear rise and an exponential decay, on a software trigger or a periodic auto-trigger. It sits on the front-end mux in place of a physical ADC channel, for bring-up and for closed-loop threshold and filter verification.

---
 rtl/adc_pulse_emulator.sv | 180 ++++++++++++++++++
 tb/tb_adc_pulse_emulator.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_pulse_emulator.sv
// Synthetic ADC sample source: negative-going pulses on a baseline.
// Linear rise, exponential decay, manual or periodic auto-trigger.
module adc_pulse_emulator #(
  parameter int DIV_W = 8,
  parameter int PER_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [15:0]      baseline,
  input  logic [15:0]      amplitude,
  input  logic [15:0]      rise_step,
  input  logic [3:0]       decay_shift,
  input  logic [PER_W-1:0] period,
  input  logic             trigger,
  output logic [15:0]      D_out,
  output logic             ADC_clk_out,
  output logic             ADC_OF,
  output logic             pulse_start,
  output logic             busy,
  output logic [7:0]       missed_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RISE  = 2'd1,
    ST_DECAY = 2'd2
  } state_t;

  logic [DIV_W-1:0] r_div_cnt;
  logic [PER_W-1:0] r_per_cnt;
  logic [15:0]      r_level;
  logic             r_pending;
  state_t           r_state;

  logic             w_tick;
  logic             w_per_last;
  logic             w_per_wrap;
  logic             w_trig;
  logic [16:0]      w_sum;
  logic [15:0]      w_first_lvl;
  logic [15:0]      w_rise_lvl;
  logic [15:0]      w_dec_raw;
  logic [15:0]      w_dec;
  logic [15:0]      w_decay_lvl;
  state_t           w_state_nxt;
  logic [15:0]      w_level_nxt;
  logic             w_start;
  logic             w_miss;
  logic signed [17:0] w_diff;
  logic             w_pos_of;
  logic             w_neg_of;
  logic             w_of;
  logic [15:0]      w_dsat;

  assign w_tick = enable && (r_div_cnt == clk_div);

  assign w_per_last = (period != '0) &&
                      (r_per_cnt == period - PER_W'(1));
  assign w_per_wrap = (period == '0) ||
                      (r_per_cnt >= period - PER_W'(1));

  assign w_trig = r_pending || trigger || w_per_last;

  assign w_sum = {1'b0, r_level} + {1'b0, rise_step};
  assign w_rise_lvl = (w_sum > {1'b0, amplitude}) ?
                      amplitude : w_sum[15:0];
  assign w_first_lvl = (rise_step > amplitude) ?
                       amplitude : rise_step;

  assign w_dec_raw = r_level >> decay_shift;
  assign w_dec = (w_dec_raw == 16'd0) ? 16'd1 : w_dec_raw;
  assign w_decay_lvl = (w_dec >= r_level) ?
                       16'd0 : r_level - w_dec;

  // Next envelope level and state for the current tick
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_start     = 1'b0;
    w_miss      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_level_nxt = 16'd0;
        if (w_trig && (amplitude != 16'd0)) begin
          w_level_nxt = w_first_lvl;
          w_start     = 1'b1;
          w_state_nxt = (w_first_lvl == amplitude) ?
                        ST_DECAY : ST_RISE;
        end
      end
      ST_RISE: begin
        w_miss      = w_trig;
        w_level_nxt = w_rise_lvl;
        if (w_rise_lvl == amplitude) begin
          w_state_nxt = (w_rise_lvl == 16'd0) ?
                        ST_IDLE : ST_DECAY;
        end
      end
      ST_DECAY: begin
        w_miss      = w_trig;
        w_level_nxt = w_decay_lvl;
        if (w_decay_lvl == 16'd0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_level_nxt = 16'd0;
      end
    endcase
  end

  assign w_diff = $signed({{2{baseline[15]}}, baseline}) -
                  $signed({2'b00, w_level_nxt});

  assign w_pos_of = ~w_diff[17] & (w_diff[16] | w_diff[15]);
  assign w_neg_of = w_diff[17] & ~(w_diff[16] & w_diff[15]);
  assign w_of     = w_pos_of | w_neg_of;
  assign w_dsat   = w_pos_of ? 16'h7FFF :
                    w_neg_of ? 16'h8000 :
                    w_diff[15:0];

  // Sample divider, auto-trigger period counter, trigger latch
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_per_cnt <= '0;
      r_pending <= 1'b0;
    end else if (!enable) begin
      r_div_cnt <= '0;
      r_pending <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_pending <= 1'b0;
      r_per_cnt <= w_per_wrap ? '0 : r_per_cnt + PER_W'(1);
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      if (trigger) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Pulse FSM with registered sample, strobe and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_level     <= 16'd0;
      D_out       <= 16'd0;
      ADC_clk_out <= 1'b0;
      ADC_OF      <= 1'b0;
      pulse_start <= 1'b0;
      busy        <= 1'b0;
      missed_cnt  <= 8'd0;
    end else if (!enable) begin
      r_state     <= ST_IDLE;
      r_level     <= 16'd0;
      ADC_clk_out <= 1'b0;
      pulse_start <= 1'b0;
      busy        <= 1'b0;
    end else if (w_tick) begin
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      D_out       <= w_dsat;
      ADC_OF      <= w_of;
      ADC_clk_out <= 1'b1;
      pulse_start <= w_start;
      busy        <= (w_state_nxt != ST_IDLE);
      if (w_miss && (missed_cnt != 8'hFF)) begin
        missed_cnt <= missed_cnt + 8'd1;
      end
    end else begin
      ADC_clk_out <= 1'b0;
      pulse_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Bench for adc_pulse_emulator: directed scenarios plus
// randomized runs against a pulse-list reference model.
module tb_adc_pulse_emulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  clk_div;
  logic [15:0] baseline;
  logic [15:0] amplitude;
  logic [15:0] rise_step;
  logic [3:0]  decay_shift;
  logic [23:0] period;
  logic        trigger;
  logic [15:0] D_out;
  logic        ADC_clk_out;
  logic        ADC_OF;
  logic        pulse_start;
  logic        busy;
  logic [7:0]  missed_cnt;

  int checks = 0;
  int failures = 0;

  int basic_exp [11] = '{-40, -80, -100, -50, -25, -13,
                         -7, -4, -2, -1, 0};

  // reference model state
  int m_clk;
  int m_ticks;
  int m_missed;
  bit m_pending;
  int m_q[$];
  bit e_strobe;
  bit e_ps;
  bit e_busy;
  bit e_of;
  int e_d;

  adc_pulse_emulator #(.DIV_W(8), .PER_W(24)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .clk_div(clk_div), .baseline(baseline),
    .amplitude(amplitude), .rise_step(rise_step),
    .decay_shift(decay_shift), .period(period),
    .trigger(trigger), .D_out(D_out),
    .ADC_clk_out(ADC_clk_out), .ADC_OF(ADC_OF),
    .pulse_start(pulse_start), .busy(busy),
    .missed_cnt(missed_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    trigger = 1'b0;
    tick_clk();
    tick_clk();
    rst = 1'b0;
  endtask

  task automatic set_params(input int div, input int base,
                            input int amp, input int step,
                            input int sh, input int per);
    enable = 1'b1;
    clk_div = 8'(div);
    baseline = 16'(base);
    amplitude = 16'(amp);
    rise_step = 16'(step);
    decay_shift = 4'(sh);
    period = 24'(per);
  endtask

  function automatic int sval(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // full level list of one pulse from the envelope rules
  task automatic build_pulse();
    int a;
    int s;
    int sh;
    int lvl;
    int d;
    a = int'(amplitude);
    s = int'(rise_step);
    sh = int'(decay_shift);
    lvl = 0;
    do begin
      lvl = (lvl + s > a) ? a : lvl + s;
      m_q.push_back(lvl);
    end while (lvl != a);
    while (lvl != 0) begin
      d = lvl >> sh;
      if (d == 0) d = 1;
      lvl = lvl - d;
      m_q.push_back(lvl);
    end
  endtask

  task automatic model_init();
    m_clk = 0;
    m_ticks = 0;
    m_missed = 0;
    m_pending = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit trg);
    bit tk;
    bit t;
    bit was_busy;
    int lvl;
    int diff;
    tk = (m_clk % (int'(clk_div) + 1)) == int'(clk_div);
    m_clk++;
    e_strobe = tk;
    e_ps = 0;
    if (!tk) begin
      if (trg) m_pending = 1;
      return;
    end
    m_ticks++;
    t = m_pending || trg ||
        (period != 0 && (m_ticks % int'(period)) == 0);
    m_pending = 0;
    was_busy = m_q.size() != 0;
    if (t && was_busy) begin
      if (m_missed < 255) m_missed++;
    end else if (t && amplitude != 0) begin
      build_pulse();
      e_ps = 1;
    end
    lvl = (m_q.size() != 0) ? m_q.pop_front() : 0;
    e_busy = m_q.size() != 0;
    diff = sval(baseline) - lvl;
    e_of = 0;
    if (diff < -32768) begin
      diff = -32768;
      e_of = 1;
    end else if (diff > 32767) begin
      diff = 32767;
      e_of = 1;
    end
    e_d = diff;
  endtask

  task automatic test_reset();
    set_params(0, 100, 50, 10, 1, 0);
    rst = 1'b1;
    trigger = 1'b0;
    tick_clk();
    tick_clk();
    checks++;
    if (D_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_dout got=%0d want=0", D_out);
    end
    checks++;
    if ({ADC_clk_out, ADC_OF, pulse_start, busy} !== 4'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000",
               {ADC_clk_out, ADC_OF, pulse_start, busy});
    end
    checks++;
    if (missed_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_missed got=%0d want=0", missed_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic_pulse();
    int ps;
    set_params(0, 0, 100, 40, 1, 0);
    do_reset();
    tick_clk();
    trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    ps = 0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy_hi got=%b want=1", busy);
    end
    for (int i = 0; i < 11; i++) begin
      if (pulse_start) ps++;
      checks++;
      if (ADC_clk_out !== 1'b1 || sval(D_out) != basic_exp[i]) begin
        failures++;
        $display("FAIL basic_seq[%0d] got=%0d/%b want=%0d/1",
                 i, sval(D_out), ADC_clk_out, basic_exp[i]);
      end
      if (i < 10) tick_clk();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_lo got=%b want=0", busy);
    end
    for (int i = 0; i < 5; i++) begin
      tick_clk();
      if (pulse_start) ps++;
    end
    checks++;
    if (D_out !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle got=%0d/%b want=0/0",
               sval(D_out), busy);
    end
    checks++;
    if (ps != 1) begin
      failures++;
      $display("FAIL basic_pulse_start got=%0d want=1", ps);
    end
  endtask

  task automatic test_saturation();
    int wd [4] = '{-32768, -32768, -32500, -32250};
    bit wo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    set_params(0, -32000, 2000, 2000, 1, 0);
    do_reset();
    tick_clk();
    trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sval(D_out) != wd[i] || ADC_OF !== wo[i]) begin
        failures++;
        $display("FAIL sat[%0d] got=%0d of=%b want=%0d of=%b",
                 i, sval(D_out), ADC_OF, wd[i], wo[i]);
      end
      tick_clk();
    end
  endtask

  task automatic test_divider_period();
    int last_s;
    int last_p;
    int np;
    int cnt;
    bit seen;
    int ps;
    set_params(3, 0, 10, 10, 1, 20);
    do_reset();
    last_s = -1;
    last_p = -1;
    np = 0;
    for (int cyc = 1; cyc <= 260; cyc++) begin
      tick_clk();
      if (ADC_clk_out) begin
        if (last_s >= 0) begin
          checks++;
          if (cyc - last_s != 4) begin
            failures++;
            $display("FAIL div_gap got=%0d want=4", cyc - last_s);
          end
        end
        last_s = cyc;
      end
      if (pulse_start) begin
        np++;
        if (last_p >= 0) begin
          checks++;
          if (cyc - last_p != 80) begin
            failures++;
            $display("FAIL per_gap got=%0d want=80", cyc - last_p);
          end
        end
        last_p = cyc;
      end
    end
    checks++;
    if (np != 3) begin
      failures++;
      $display("FAIL per_count got=%0d want=3", np);
    end
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick_clk();
      if (pulse_start) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL per_wait got=timeout want=pulse_start");
    end
    period = 24'd0;
    cnt = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      tick_clk();
      if (ADC_clk_out) cnt++;
    end
    checks++;
    if (cnt != 5 || busy !== 1'b0 || D_out !== 16'd0) begin
      failures++;
      $display("FAIL per_finish got=%0d/%b/%0d want=5/0/0",
               cnt, busy, sval(D_out));
    end
    ps = 0;
    for (int i = 0; i < 200; i++) begin
      tick_clk();
      if (pulse_start) ps++;
    end
    checks++;
    if (ps != 0) begin
      failures++;
      $display("FAIL per_off got=%0d want=0", ps);
    end
  endtask

  task automatic test_missed();
    int ps;
    set_params(0, 0, 65535, 65535, 15, 0);
    do_reset();
    trigger = 1'b1;
    tick_clk();
    ps = 0;
    for (int i = 0; i < 300; i++) begin
      tick_clk();
      if (pulse_start) ps++;
      if (i == 99) begin
        checks++;
        if (missed_cnt !== 8'd100) begin
          failures++;
          $display("FAIL missed_100 got=%0d want=100", missed_cnt);
        end
      end
    end
    trigger = 1'b0;
    tick_clk();
    checks++;
    if (missed_cnt !== 8'd255) begin
      failures++;
      $display("FAIL missed_sat got=%0d want=255", missed_cnt);
    end
    checks++;
    if (ps != 0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL missed_extra got=%0d/%b want=0/1", ps, busy);
    end
    checks++;
    if (sval(D_out) != -32768 || ADC_OF !== 1'b1) begin
      failures++;
      $display("FAIL missed_of got=%0d/%b want=-32768/1",
               sval(D_out), ADC_OF);
    end
  endtask

  task automatic test_reset_enable();
    logic [15:0] hold;
    int n;
    set_params(0, 0, 1000, 10, 2, 0);
    do_reset();
    trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    tick_clk();
    tick_clk();
    trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    checks++;
    if (missed_cnt !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rise_missed got=%0d/%b want=1/1",
               missed_cnt, busy);
    end
    rst = 1'b1;
    tick_clk();
    checks++;
    if ({D_out, ADC_clk_out, ADC_OF, pulse_start, busy,
         missed_cnt} !== 28'd0) begin
      failures++;
      $display("FAIL midrst got=%0d/%b%b%b%b/%0d want=all0",
               D_out, ADC_clk_out, ADC_OF, pulse_start,
               busy, missed_cnt);
    end
    rst = 1'b0;
    baseline = 16'd1234;
    tick_clk();
    checks++;
    if (ADC_clk_out !== 1'b1 || D_out !== 16'd1234 || busy) begin
      failures++;
      $display("FAIL post_rst got=%0d/%b/%b want=1234/1/0",
               D_out, ADC_clk_out, busy);
    end
    amplitude = 16'd1000;
    rise_step = 16'd1000;
    decay_shift = 4'd4;
    trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    tick_clk();
    tick_clk();
    hold = D_out;
    enable = 1'b0;
    tick_clk();
    checks++;
    if (ADC_clk_out !== 1'b0 || busy !== 1'b0 || D_out !== hold) begin
      failures++;
      $display("FAIL dis got=%b/%b/%0d want=0/0/%0d",
               ADC_clk_out, busy, sval(D_out), sval(hold));
    end
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick_clk();
      if (ADC_clk_out) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL dis_strobes got=%0d want=0", n);
    end
    enable = 1'b1;
  endtask

  task automatic test_edge();
    int ps;
    int at;
    set_params(0, -500, 0, 10, 1, 0);
    do_reset();
    trigger = 1'b1;
    tick_clk();
    trigger = 1'b0;
    ps = 0;
    if (pulse_start) ps++;
    for (int i = 0; i < 8; i++) begin
      tick_clk();
      if (pulse_start) ps++;
    end
    checks++;
    if (ps != 0 || missed_cnt !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL amp0 got=%0d/%0d/%b want=0/0/0",
               ps, missed_cnt, busy);
    end
    checks++;
    if (sval(D_out) != -500) begin
      failures++;
      $display("FAIL amp0_base got=%0d want=-500", sval(D_out));
    end
    set_params(0, 0, 10, 10, 4, 50);
    do_reset();
    ps = 0;
    at = -1;
    for (int i = 1; i <= 40; i++) begin
      trigger = (i == 5);
      tick_clk();
      if (pulse_start) begin
        ps++;
        at = i;
      end
    end
    trigger = 1'b0;
    checks++;
    if (ps != 1 || at != 5 || missed_cnt !== 8'd0) begin
      failures++;
      $display("FAIL coincident got=%0d@%0d/%0d want=1@5/0",
               ps, at, missed_cnt);
    end
  endtask

  task automatic test_random();
    bit trg;
    for (int run = 0; run < 6; run++) begin
      set_params($urandom_range(0, 3),
                 int'($urandom_range(0, 65535)) - 32768,
                 ($urandom_range(0, 7) == 0) ? 0 :
                   $urandom_range(1, 4000),
                 $urandom_range(1, 2000),
                 $urandom_range(0, 5),
                 ($urandom_range(0, 2) == 0) ? 0 :
                   $urandom_range(5, 80));
      do_reset();
      model_init();
      for (int c = 0; c < 800; c++) begin
        trg = ($urandom_range(0, 39) == 0);
        trigger = trg;
        model_step(trg);
        tick_clk();
        checks++;
        if (ADC_clk_out !== e_strobe ||
            pulse_start !== e_ps) begin
          failures++;
          $display("FAIL rnd_strobe r%0d c%0d got=%b%b want=%b%b",
                   run, c, ADC_clk_out, pulse_start,
                   e_strobe, e_ps);
        end
        if (e_strobe) begin
          checks++;
          if (sval(D_out) != e_d || ADC_OF !== e_of ||
              busy !== e_busy) begin
            failures++;
            $display("FAIL rnd_sample r%0d c%0d got=%0d/%b/%b want=%0d/%b/%b",
                     run, c, sval(D_out), ADC_OF, busy,
                     e_d, e_of, e_busy);
          end
        end
        checks++;
        if (int'(missed_cnt) != m_missed) begin
          failures++;
          $display("FAIL rnd_missed r%0d c%0d got=%0d want=%0d",
                   run, c, missed_cnt, m_missed);
        end
      end
      trigger = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    trigger = 1'b0;
    set_params(0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic_pulse();
    test_saturation();
    test_divider_period();
    test_missed();
    test_reset_enable();
    test_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
